// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle and runs loads/stores
// on a simple req/ack data bus. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [4:0]        rd_i,
  input  logic              reg_write_i,
  input  logic              flush_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t      state_q, state_nxt;
  logic        accept, is_mem, mis, load_now, ack_take;
  logic [4:0]  rd_p1;
  logic        regw_p1;
  logic        discard_p1;

  assign is_mem = mem_read_i | mem_write_i;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem & (|alu_out_i[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign accept   = in_valid & in_ready;
  assign load_now = accept & (!is_mem | mis);
  // A flushed bus transaction still completes, but its result never reaches writeback.
  assign ack_take = (state_q == BUS) & mem_ack & !discard_p1 & !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !mis) state_nxt = BUS;
      BUS:     if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == BUS);
    mem_req  = (state_q == BUS);
    in_ready = (state_q == IDLE) & (!out_valid | out_ready) & !flush_i;
  end

  // Bus request stage: operands latched on acceptance, stable for the whole transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      rd_p1      <= '0;
      regw_p1    <= 1'b0;
      discard_p1 <= 1'b0;
    end else if (accept && is_mem && !mis) begin
      mem_addr   <= {alu_out_i[DATA_W-1:2], 2'b00};
      mem_wdata  <= wdata_i;
      mem_we     <= mem_write_i;
      rd_p1      <= rd_i;
      regw_p1    <= reg_write_i;
      discard_p1 <= 1'b0;
    end else if ((state_q == BUS) && flush_i) begin
      discard_p1 <= 1'b1;
    end
  end

  // Writeback stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      if (flush_i)                     out_valid <= 1'b0;
      else if (load_now || ack_take)   out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;

      if (load_now) begin
        wb_data      <= alu_out_i;
        wb_rd        <= rd_i;
        wb_reg_write <= reg_write_i & !mis;
      end else if (ack_take) begin
        wb_data      <= mem_we ? mem_addr : mem_rdata;
        wb_rd        <= rd_p1;
        wb_reg_write <= regw_p1 & !mem_we;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      misalign <= 1'b0;
    else if (flush_i)                misalign <= 1'b0;
    else if (load_now)               misalign <= mis;
    else if (ack_take)               misalign <= 1'b0;
    else if (out_valid && out_ready) misalign <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected writeback results,
// a monitor pops and compares on every out_valid & out_ready handshake.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] alu_out_i = '0, wdata_i = '0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        reg_write_i = 1'b0, flush_i = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, busy, misalign_w;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out_i(alu_out_i), .wdata_i(wdata_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .flush_i(flush_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .busy(busy)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign_w)
`endif
  );
`ifndef MEM_MISALIGN_TRAP_EN
  assign misalign_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic cd, input logic [4:0] rd,
                      input logic rw, input logic mis);
    exp_t e;
    e.data = d; e.chk_data = cd; e.rd = rd; e.rw = rw; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic rw);
    in_valid = 1'b1; alu_out_i = a; wdata_i = wd; rd_i = rd;
    mem_read_i = mr; mem_write_i = mw; reg_write_i = rw;
    @(negedge clk);
    chk("in_ready_at_issue", in_ready, 1);
    cyc();
    in_valid = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  // Monitor: every accepted writeback result must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
        chk("misalign", {31'd0, misalign_w}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_misalign", misalign_w, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Non-memory ops, one per cycle
    push(32'h7, 1, 5'd3, 1, 0);
    issue(32'h7, 0, 5'd3, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      push(32'h10 + i, 1, 5'(4 + i), 1, 0);
      issue(32'h10 + i, 0, 5'(4 + i), 0, 0, 1);
    end
    @(negedge clk);
    chk("b2b_out_valid", out_valid, 1);
    cyc();

    // Load 0x100, ack on third bus cycle
    push(32'hDEAD_BEEF, 1, 5'd5, 1, 0);
    issue(32'h100, 0, 5'd5, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      chk("ld_mem_req", mem_req, 1);
      chk("ld_mem_addr", mem_addr, 32'h100);
      chk("ld_mem_we", mem_we, 0);
      chk("ld_out_valid_low", out_valid, 0);
      chk("ld_in_ready_low", in_ready, 0);
      cyc();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("ld_mem_req_drop", mem_req, 0);
    chk("ld_out_valid", out_valid, 1);
    cyc();

    // Store 0x204 / 0x55
    push(32'h0, 0, 5'd7, 0, 0);
    issue(32'h204, 32'h55, 5'd7, 0, 1, 1);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_mem_req", mem_req, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h204);
    chk("st_mem_wdata", mem_wdata, 32'h55);
    cyc();
    mem_ack = 1'b0;
    cyc();

    // Both flags set behaves as a store
    push(32'h0, 0, 5'd8, 0, 0);
    issue(32'h300, 32'h99, 5'd8, 1, 1, 1);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rw_mem_we", mem_we, 1);
    cyc();
    mem_ack = 1'b0;
    cyc();

    // Backpressure: result held, new op stalled
    out_ready = 1'b0;
    push(32'h11, 1, 5'd1, 1, 0);
    issue(32'h11, 0, 5'd1, 0, 0, 1);
    in_valid = 1'b1; alu_out_i = 32'h22; rd_i = 5'd2; reg_write_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_wb_data_hold", wb_data, 32'h11);
      chk("bp_out_valid", out_valid, 1);
      cyc();
    end
    push(32'h22, 1, 5'd2, 1, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    cyc();

    // Flush during BUS: store still completes, result dropped
    issue(32'h400, 32'hAA, 5'd9, 0, 1, 1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_mem_req", mem_req, 1);
    chk("fl_in_ready", in_ready, 0);
    cyc();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_mem_req_hold", mem_req, 1);
    chk("fl_mem_we_hold", mem_we, 1);
    cyc();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("fl_mem_req_ack", mem_req, 1);
    cyc();
    mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fl_no_out_valid", out_valid, 0);
      chk("fl_busy", busy, 0);
      cyc();
    end

    // Flush and ack in the same cycle
    issue(32'h500, 0, 5'd10, 1, 0, 1);
    flush_i = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    flush_i = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("flack_out_valid", out_valid, 0);
    chk("flack_busy", busy, 0);
    cyc();

    // Flush clears a held result
    out_ready = 1'b0;
    issue(32'h33, 0, 5'd11, 0, 0, 1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flh_in_ready", in_ready, 0);
    cyc();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flh_out_valid", out_valid, 0);
    cyc();
    out_ready = 1'b1;

    // Reset mid-BUS, then a late ack
    issue(32'h600, 32'h77, 5'd12, 0, 1, 1);
    @(negedge clk);
    chk("rb_mem_req", mem_req, 1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rb_mem_req_async", mem_req, 0);
    chk("rb_busy_async", busy, 0);
    chk("rb_mem_we_async", mem_we, 0);
    chk("rb_mem_addr_async", mem_addr, 0);
    chk("rb_mem_wdata_async", mem_wdata, 0);
    cyc();
    rst_n = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("rb_late_ack_busy", busy, 0);
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rb_late_ack_out_valid", out_valid, 0);
    chk("rb_late_ack_mem_req", mem_req, 0);
    cyc();

    // Misaligned address 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    push(32'h0, 0, 5'd13, 0, 1);
    issue(32'h102, 0, 5'd13, 1, 0, 1);
    @(negedge clk);
    chk("mis_mem_req", mem_req, 0);
    chk("mis_busy", busy, 0);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_flag", misalign_w, 1);
    cyc();
    @(negedge clk);
    chk("mis_flag_clear", misalign_w, 0);
    cyc();
`else
    push(32'hCAFE_0001, 1, 5'd13, 1, 0);
    issue(32'h102, 0, 5'd13, 1, 0, 1);
    @(negedge clk);
    chk("mis_mem_req", mem_req, 1);
    chk("mis_mem_addr_aligned", mem_addr, 32'h100);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    cyc();
    mem_ack = 1'b0;
    cyc();
`endif

    repeat (3) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
